// File: rtl/memory_arbiter_if.sv
// ----------------------------------------------------------------------------
// memory_arbiter_if
// Bundles everything between the arbiter, its two requesters (instruction and
// data side) and the single-ported RAM.
//
// Parameters
//   ADDR_W  address width
//   DATA_W  data word width
//
// Signals
//   iREN, iaddr               instruction read request (held until ihit)
//   dREN, dWEN, daddr, dstore data read/write request (held until dhit)
//   ihit, dhit                one-cycle completion pulses
//   iload, dload              last captured instruction / data read words
//   ramREN, ramWEN            RAM read / write strobes
//   ramaddr, ramstore         RAM address / write data
//   ramload, ramready         RAM read data and access-complete flag
//   timeout_err               one-cycle pulse on an aborted access
//
// Modports
//   master  the arbiter's view: takes requests and RAM responses, drives the
//           completion signals and the RAM strobes
//   slave   the environment's view (requesters plus RAM): the mirror image
// ----------------------------------------------------------------------------
interface memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              ihit;
    logic              dhit;
    logic [DATA_W-1:0] iload;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ramready;
    logic              timeout_err;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               timeout_err
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               timeout_err
    );
endinterface

// File: rtl/memory_arbiter.sv
// ----------------------------------------------------------------------------
// memory_arbiter
// Shares one RAM port between an instruction requester and a data requester.
// Data requests win over instruction requests. One access is in flight at a
// time: IDLE arbitrates, DACC/IACC hold the RAM strobes until ramready, HIT
// raises the matching completion pulse for one cycle. An access that never
// sees ramready is abandoned after TIMEOUT wait cycles with a timeout_err
// pulse; an access whose requester lets go mid-flight is dropped silently.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data word width
//   TIMEOUT  wait cycles (1..255) tolerated before an access is aborted
//
// Ports
//   CLK      clock, rising edge
//   nRST     asynchronous, active-low reset
//   bus      memory_arbiter_if.master (requests, completions, RAM side)
//
// All outputs are registered: the RAM strobes are loaded on the edge that
// enters an ACC state and cleared on the edge that leaves it, so they are
// high exactly while the FSM sits in DACC or IACC.
// ----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             nRST,
    memory_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        HIT  = 2'd3
    } state_t;

    // The wait counter is 8 bits wide, so only the low byte of TIMEOUT counts.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] waitcnt;
    logic       reqwrite;
    logic       withdrawn;

    // The requester of the access in flight dropped its request line. Only
    // meaningful in DACC/IACC.
    always_comb begin
        withdrawn = 1'b0;
        if (state == DACC) begin
            withdrawn = !(bus.dREN || bus.dWEN);
        end else if (state == IACC) begin
            withdrawn = !bus.iREN;
        end
    end

    // Single FSM process. The latched request lives in ramaddr/ramstore plus
    // reqwrite; the address and store data only need to exist while the RAM
    // is being driven, so there is no separate copy.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state           <= IDLE;
            waitcnt         <= '0;
            reqwrite        <= 1'b0;
            bus.ihit        <= 1'b0;
            bus.dhit        <= 1'b0;
            bus.iload       <= '0;
            bus.dload       <= '0;
            bus.ramREN      <= 1'b0;
            bus.ramWEN      <= 1'b0;
            bus.ramaddr     <= '0;
            bus.ramstore    <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            // Completion and error outputs are single-cycle pulses.
            bus.ihit        <= 1'b0;
            bus.dhit        <= 1'b0;
            bus.timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.dREN || bus.dWEN) begin
                        // A combined read+write request is a write.
                        state        <= DACC;
                        waitcnt      <= '0;
                        reqwrite     <= bus.dWEN;
                        bus.ramREN   <= !bus.dWEN;
                        bus.ramWEN   <= bus.dWEN;
                        bus.ramaddr  <= bus.daddr;
                        bus.ramstore <= bus.dstore;
                    end else if (bus.iREN) begin
                        state        <= IACC;
                        waitcnt      <= '0;
                        reqwrite     <= 1'b0;
                        bus.ramREN   <= 1'b1;
                        bus.ramWEN   <= 1'b0;
                        bus.ramaddr  <= bus.iaddr;
                        bus.ramstore <= '0;
                    end
                end

                DACC, IACC: begin
                    // Withdrawal wins over everything: the requester no longer
                    // wants the result, so neither a hit nor an error is raised.
                    if (withdrawn) begin
                        state        <= IDLE;
                        bus.ramREN   <= 1'b0;
                        bus.ramWEN   <= 1'b0;
                        bus.ramaddr  <= '0;
                        bus.ramstore <= '0;
                    end else if (bus.ramready) begin
                        state        <= HIT;
                        bus.ramREN   <= 1'b0;
                        bus.ramWEN   <= 1'b0;
                        bus.ramaddr  <= '0;
                        bus.ramstore <= '0;
                        if (state == DACC) begin
                            bus.dhit <= 1'b1;
                            if (!reqwrite) begin
                                bus.dload <= bus.ramload;
                            end
                        end else begin
                            bus.ihit  <= 1'b1;
                            bus.iload <= bus.ramload;
                        end
                    end else if (waitcnt == WAIT_LIMIT - 8'd1) begin
                        // This is the TIMEOUT-th cycle without ramready.
                        state           <= IDLE;
                        waitcnt         <= '0;
                        bus.timeout_err <= 1'b1;
                        bus.ramREN      <= 1'b0;
                        bus.ramWEN      <= 1'b0;
                        bus.ramaddr     <= '0;
                        bus.ramstore    <= '0;
                    end else begin
                        waitcnt <= waitcnt + 8'd1;
                    end
                end

                HIT: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// ----------------------------------------------------------------------------
// tb_memory_arbiter
// Directed scenarios followed by randomized transactions. Each transaction is
// described by what the environment does (request kind, address, data, how
// many cycles the RAM stalls, whether the requester gives up early) and the
// expected outcome is derived from that description alone: hit after
// waits+1 access cycles, abort after TIMEOUT stalled cycles, or a silent drop.
// The bench plays both requesters and the RAM; outputs are sampled on the
// falling edge, inputs change right after sampling.
// ----------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference state: the words the requesters last received.
    logic [DW-1:0] expIload = '0;
    logic [DW-1:0] expDload = '0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic ren, input logic wen,
                            input logic [AW-1:0] addr, input logic [DW-1:0] store,
                            input logic ih, input logic dh, input logic err);
        checkOutput({tag, " ramREN"},      64'(bus.ramREN),      64'(ren));
        checkOutput({tag, " ramWEN"},      64'(bus.ramWEN),      64'(wen));
        checkOutput({tag, " ramaddr"},     64'(bus.ramaddr),     64'(addr));
        checkOutput({tag, " ramstore"},    64'(bus.ramstore),    64'(store));
        checkOutput({tag, " ihit"},        64'(bus.ihit),        64'(ih));
        checkOutput({tag, " dhit"},        64'(bus.dhit),        64'(dh));
        checkOutput({tag, " timeout_err"}, 64'(bus.timeout_err), 64'(err));
        checkOutput({tag, " iload"},       64'(bus.iload),       64'(expIload));
        checkOutput({tag, " dload"},       64'(bus.dload),       64'(expDload));
    endtask

    task automatic applyStimulus(input logic iren, input logic [AW-1:0] ia,
                                 input logic dren, input logic dwen,
                                 input logic [AW-1:0] da, input logic [DW-1:0] ds);
        bus.iREN   = iren;
        bus.iaddr  = ia;
        bus.dREN   = dren;
        bus.dWEN   = dwen;
        bus.daddr  = da;
        bus.dstore = ds;
    endtask

    // One transaction. Entered at a falling edge with the arbiter idle; left
    // at a falling edge with the arbiter idle again. The RAM stalls `waits`
    // cycles and answers with `word` on access cycle waits+1. A nonzero
    // `withdrawAt` makes the requester drop its line on that access cycle.
    // Any other pending request (e.g. a held iREN) is left untouched.
    task automatic serve(input string tag, input bit isData, input bit rd, input bit wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] store,
                         input int waits, input int withdrawAt, input logic [DW-1:0] word);
        bit            write;
        logic [DW-1:0] expStore;
        int            outcome;
        int            k;
        write    = isData && wr;
        expStore = isData ? store : '0;
        if (isData) begin
            bus.dREN   = rd;
            bus.dWEN   = wr;
            bus.daddr  = addr;
            bus.dstore = store;
        end else begin
            bus.iREN  = 1'b1;
            bus.iaddr = addr;
        end
        // RAM noise while idle must be ignored.
        bus.ramready = 1'($urandom_range(0, 1));
        bus.ramload  = $urandom;

        outcome = -1;
        k       = 0;
        while (outcome < 0) begin
            @(negedge CLK);
            k++;
            checkAll({tag, "/acc"}, !write, write, addr, expStore, 1'b0, 1'b0, 1'b0);
            bus.ramready = 1'b0;
            bus.ramload  = $urandom;
            if (k == withdrawAt) begin
                if (isData) begin
                    bus.dREN = 1'b0;
                    bus.dWEN = 1'b0;
                end else begin
                    bus.iREN = 1'b0;
                end
                outcome = 1;
            end else if (k == waits + 1) begin
                bus.ramready = 1'b1;
                bus.ramload  = word;
                outcome      = 0;
            end else if (k == TO) begin
                outcome = 2;
            end
        end

        @(negedge CLK);
        if (outcome == 0) begin
            if (!isData) expIload = word;
            else if (!write) expDload = word;
            checkAll({tag, "/hit"}, 1'b0, 1'b0, '0, '0, !isData, isData, 1'b0);
        end else if (outcome == 1) begin
            checkAll({tag, "/drop"}, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        end else begin
            checkAll({tag, "/tmo"}, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        end
        if (isData) begin
            bus.dREN = 1'b0;
            bus.dWEN = 1'b0;
        end else begin
            bus.iREN = 1'b0;
        end
        bus.ramready = 1'($urandom_range(0, 1));
        bus.ramload  = $urandom;

        @(negedge CLK);
        checkAll({tag, "/idle"}, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] ia;
        logic [DW-1:0] s;
        logic [DW-1:0] savedDload;
        int            kind;
        int            waits;
        int            wd;
        int            lim;
        bit            pend;

        nRST = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        bus.ramready = 1'b0;
        bus.ramload  = '0;
        repeat (2) @(negedge CLK);
        checkAll("reset", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        nRST = 1'b1;
        @(negedge CLK);
        checkAll("post_reset", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Instruction fetch, RAM answers on the first access cycle.
        serve("fetch", 1'b0, 1'b0, 1'b0, 32'h40, '0, 0, 0, 32'h8C010004);
        checkOutput("fetch iload const", 64'(bus.iload), 64'h8C010004);

        // Simultaneous requests: data first, then the held instruction.
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h44;
        serve("prio_d", 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1, 0, 32'h12345678);
        serve("prio_i", 1'b0, 1'b0, 1'b0, 32'h44, '0, 0, 0, 32'hCAFEF00D);
        checkOutput("prio dload const", 64'(bus.dload), 64'h12345678);

        // Write with four stall cycles must leave dload alone.
        savedDload = expDload;
        serve("write", 1'b1, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 4, 0, 32'h55AA55AA);
        checkOutput("write dload kept", 64'(bus.dload), 64'(savedDload));

        // Read+write together behaves as a write.
        serve("rdwr", 1'b1, 1'b1, 1'b1, 32'h204, 32'h0BADF00D, 0, 0, 32'h77777777);

        // RAM never answers: abort after TIMEOUT cycles.
        serve("tmo", 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 20, 0, 32'h0);
        serve("tmo_i", 1'b0, 1'b0, 1'b0, 32'h304, '0, TO, 0, 32'h0);

        // Ready on the last cycle before the limit still completes.
        serve("late", 1'b1, 1'b1, 1'b0, 32'h308, 32'h0, TO - 1, 0, 32'h600DCAFE);

        // Requester gives up on the second access cycle.
        serve("drop", 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5, 2, 32'h0);

        // Reset in the middle of an instruction access.
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h80;
        @(negedge CLK);
        checkAll("rst_acc", 1'b1, 1'b0, 32'h80, '0, 1'b0, 1'b0, 1'b0);
        nRST = 1'b0;
        #1;
        expIload = '0;
        expDload = '0;
        checkAll("rst_async", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        bus.iREN = 1'b0;
        @(negedge CLK);
        checkAll("rst_hold", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        nRST = 1'b1;
        serve("rst_after", 1'b0, 1'b0, 1'b0, 32'h80, '0, 2, 0, 32'h13579BDF);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            kind  = $urandom_range(0, 3);
            waits = $urandom_range(0, 10);
            lim   = (waits < TO - 1) ? waits : TO - 1;
            wd    = (waits > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, lim) : 0;
            a     = $urandom;
            s     = $urandom;
            pend  = (kind != 0) && (wd == 0) && (waits < TO) && ($urandom_range(0, 3) == 0);
            if (pend) begin
                ia        = $urandom;
                bus.iREN  = 1'b1;
                bus.iaddr = ia;
            end
            case (kind)
                0: serve("rnd_i",  1'b0, 1'b0, 1'b0, a, s, waits, wd, $urandom);
                1: serve("rnd_dr", 1'b1, 1'b1, 1'b0, a, s, waits, wd, $urandom);
                2: serve("rnd_dw", 1'b1, 1'b0, 1'b1, a, s, waits, wd, $urandom);
                default: serve("rnd_drw", 1'b1, 1'b1, 1'b1, a, s, waits, wd, $urandom);
            endcase
            if (pend) begin
                serve("rnd_pend", 1'b0, 1'b0, 1'b0, ia, '0, $urandom_range(0, 3), 0, $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
